sysid_checker: RTL
==================

Name: sysid_checker

Overview:
- Avalon-MM master that reads a two-word system-ID slave after reset, or on request: word 0 = ID, word 1 = timestamp.
- Compares both words against build-time expected values and reports pass/fail/timeout as sticky status.
- Sits between the system-ID slave (via interconnect) and board-level status LEDs / the test controller.
- Lets the host and the hardware image be confirmed as matched before SRAM tests run.

Parameters:
- EXPECTED_ID, 611894095, expected 32-bit value at word address 0.
- EXPECTED_TS, 1557996746, expected 32-bit value at word address 1.
- TIMEOUT_CYCLES, 255, max cycles per read transaction (request + response); range 1..255.
- AUTO_START, 1, when 1 a check starts automatically on the first cycle after reset release.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run a check; ignored while busy.
- avm_address  output  1  word address to the slave (0 = ID, 1 = timestamp).
- avm_read  output  1  read request.
- avm_waitrequest  input  1  slave stall; request accepted in a cycle where avm_read=1 and avm_waitrequest=0.
- avm_readdata  input  32  read data, valid when avm_readdatavalid=1.
- avm_readdatavalid  input  1  read response strobe.
- busy  output  1  check in progress.
- done  output  1  level; set when a check finishes, cleared at next check start.
- id_ok  output  1  captured ID equals EXPECTED_ID.
- ts_ok  output  1  captured timestamp equals EXPECTED_TS.
- timeout_err  output  1  a transaction exceeded TIMEOUT_CYCLES.
- id_value  output  32  last captured ID word.
- ts_value  output  32  last captured timestamp word.

Behaviour:
- Reset (async assert, sync-release use):
  - All outputs 0.
  - State IDLE.
  - Timeout counter 0.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, FIN.
- IDLE → ID_REQ:
  - On start=1, or on the first cycle after reset when AUTO_START=1.
  - Entering ID_REQ clears done, id_ok, ts_ok, timeout_err; busy=1 from the next cycle.
- ID_REQ:
  - avm_read=1, avm_address=0, held stable while avm_waitrequest=1.
  - On acceptance → ID_WAIT; avm_read drops the next cycle (one outstanding read max).
- ID_WAIT:
  - On avm_readdatavalid=1: capture id_value, set id_ok=(avm_readdata==EXPECTED_ID), → TS_REQ.
  - Response latency ≥1 cycle after acceptance; readdatavalid is sampled only in *_WAIT states and ignored elsewhere.
- TS_REQ / TS_WAIT: identical to the ID states with address 1; capture into ts_value and ts_ok, then → FIN.
- FIN: done=1, busy=0, → IDLE in the same cycle; status holds until the next start.
- Timeout:
  - 8-bit counter cleared on entering each *_REQ state; increments every cycle in *_REQ/*_WAIT.
  - When counter == TIMEOUT_CYCLES-1 and the transaction is incomplete: timeout_err=1, avm_read=0 next cycle, → FIN.
  - Remaining ok flags stay 0.
- Mismatch does not abort: both words are always read when the slave responds.
- start in any state other than IDLE is ignored; start coincident with FIN completion is ignored.
- Reset mid-transaction: immediate return to IDLE with outputs 0. The slave is stateless, so no drain is needed.
- No pipelining: worst-case check time is 2*TIMEOUT_CYCLES+2 cycles.

Decomposition:
- Shared package sysid_pkg:
  - State enum.
  - Word address constants SYSID_ADDR_ID=0, SYSID_ADDR_TS=1.
  - Default expected-value constants, regenerated with the system build.
- Single flat module; no sub-module warranted. The timeout counter is inline.

Test Plan:
- AUTO_START=1, zero-wait slave returning 611894095 / 1557996746, readdatavalid 1 cycle after acceptance → addresses 0 then 1 issued; done=1, id_ok=1, ts_ok=1, timeout_err=0 within 6 cycles of reset release.
- Slave returns ID 0x00000000 → id_ok=0, ts_ok=1, id_value=0, done=1; the timestamp read is still performed.
- avm_waitrequest held 3 cycles on each read → avm_read and avm_address stable throughout; exactly one acceptance per word; pass result.
- Slave never asserts readdatavalid for the TS read, TIMEOUT_CYCLES=16 → timeout_err=1, id_ok=1, ts_ok=0, done=1, avm_read=0 after 16 cycles in TS states.
- start pulsed while busy, then again after done → first pulse ignored; second clears done and reruns the full check.
- reset_n asserted during ID_WAIT → all outputs 0 asynchronously; AUTO_START check reruns after release and passes.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM states, slave word map and
// the expected ID/timestamp words stamped in by the system build.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    FIN
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Regenerated with each system build.
  localparam logic [31:0] SYSID_EXPECTED_ID = 32'd611894095;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1557996746;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the two system-ID words, compares them with the
// build-time values and holds a sticky pass/fail/timeout status.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] tcnt;
  logic       auto_pend;
  logic       accept;
  logic       last;

  assign accept = avm_read && !avm_waitrequest;
  assign last   = (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tcnt        <= 8'd0;
      auto_pend   <= AUTO_START;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            state       <= ID_REQ;
            tcnt        <= 8'd0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        // The last counted cycle wins over a late acceptance: the response could
        // not land inside the budget anyway.
        ID_REQ, TS_REQ: begin
          tcnt <= tcnt + 8'd1;
          if (last) begin
            timeout_err <= 1'b1;
            avm_read    <= 1'b0;
            state       <= FIN;
          end else if (accept) begin
            avm_read <= 1'b0;
            state    <= (state == ID_REQ) ? ID_WAIT : TS_WAIT;
          end
        end
        ID_WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (avm_readdatavalid) begin
            id_value    <= avm_readdata;
            id_ok       <= (avm_readdata == EXPECTED_ID);
            state       <= TS_REQ;
            tcnt        <= 8'd0;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
          end else if (last) begin
            timeout_err <= 1'b1;
            state       <= FIN;
          end
        end
        TS_WAIT: begin
          tcnt <= tcnt + 8'd1;
          if (avm_readdatavalid) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TS);
            state    <= FIN;
          end else if (last) begin
            timeout_err <= 1'b1;
            state       <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
